// File: rtl/sram_burst_reader.sv
// Burst reader: streams `length` consecutive SRAM words starting at `base_addr`
// through a 4-entry FIFO to a valid/ready sink, with credit-based read issue.
module sram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [1:0]            dbg_state
);

    // Output stream: a word moves when out_valid & out_ready are both high at a
    // rising edge; while out_valid=1 and out_ready=0 the word and out_last hold.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  en_q, en_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] mem_q [4];
    logic [DATA_WIDTH-1:0] mem_d [4];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q, count_d;

    logic                  fifo_valid;
    logic                  pop;
    logic                  credit_ok;
    logic                  last_word;

    assign fifo_valid = (count_q != 3'd0);
    assign pop        = fifo_valid && out_ready;
    assign last_word  = (pop_cnt_q == (len_q - ONE_A));
    // Reads issued but not yet landed plus buffered words must leave room for
    // the read about to be scheduled, so the FIFO can never overflow.
    assign credit_ok  = (({2'b00, en_q} + {2'b00, rd_q} + count_q) < 3'd4);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop ? (pop_cnt_q + ONE_A) : pop_cnt_q;
        addr_d      = addr_q;
        en_d        = 1'b0;
        rd_d        = en_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + {2'b00, rd_q} - {2'b00, pop};

        if (rd_q) begin
            mem_d[wr_ptr_q] = sram_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = length;
                    pop_cnt_d = '0;
                    if (length != '0) begin
                        state_d     = READ;
                        en_d        = 1'b1;
                        addr_d      = base_addr;
                        issue_cnt_d = ONE_A;
                    end else begin
                        state_d     = DONE;
                        issue_cnt_d = '0;
                    end
                end
            end
            READ: begin
                if (issue_cnt_q != len_q) begin
                    if (credit_ok) begin
                        en_d        = 1'b1;
                        addr_d      = addr_q + ONE_A;
                        issue_cnt_d = issue_cnt_q + ONE_A;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_en   = en_q;
    assign sram_we   = 1'b0;
    assign sram_addr = addr_q;
    assign out_valid = fifo_valid;
    // Gate with valid so stale FIFO contents never show on the output bus.
    assign out_data  = fifo_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last  = fifo_valid && last_word;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: SRAM model, address/data scoreboard,
// latency, credit, wrap-around, zero-length, mid-burst reset and start-hold cases.
module tb_sram_burst_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp_addr_q[$];

    sram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // synchronous-read SRAM: data appears the cycle after an enabled cycle
    initial sram_data = 8'h00;
    always @(posedge clk) begin
        if (sram_en) sram_data <= ram_f(sram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_en"},    sram_en, 0);
        chk({tag, "_we"},    sram_we, 0);
        chk({tag, "_addr"},  sram_addr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_data"},  out_data, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // mode 0: out_ready high; mode 1: ready low 8 cycles then random.
    // hold: keep start high and scramble base/length after acceptance.
    // rst_at > 0: pulse reset after that many words are accepted.
    task automatic run_burst(input logic [15:0] base, input logic [15:0] len,
                             input int mode, input bit hold, input int rst_at);
        int issued = 0, popped = 0;
        int first_en = -1, first_v = -1, last_hs = -1, done_c = -1;
        bit fin = 0, aborted = 0;
        bit prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        logic prev_last = 1'b0;
        logic [7:0] w;
        for (int k = 0; k < int'(len); k++) begin
            exp_addr_q.push_back(base + 16'(k));
            exp_q.push_back(ram_f(base + 16'(k)));
        end
        base_addr = base;
        length    = len;
        start     = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        else begin
            base_addr = base + 16'h0100;
            length    = len + 16'd1;
        end
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_after_start", busy, len != 0);
            chk("sram_we", sram_we, 0);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (sram_en) begin
                if (first_en < 0) first_en = c;
                chk("credit", (issued - popped) <= 3, 1);
                if (exp_addr_q.size() == 0) chk("extra_issue", 1, 0);
                else chk("sram_addr", sram_addr, exp_addr_q.pop_front());
                issued++;
            end
            if (out_valid && first_v < 0) first_v = c;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    chk("out_data", out_data, w);
                    chk("out_last", out_last, exp_q.size() == 0);
                end
                popped++;
                last_hs = c;
                if (rst_at > 0 && popped == rst_at) begin
                    #2 reset_n = 1'b0;
                    #1 chk_cleared("reset_mid");
                    aborted = 1;
                    fin = 1;
                end
            end
            if (!aborted && done) begin
                done_c = c;
                fin = 1;
            end
            if (mode == 1 && c == 8) chk("stall_issues", issued, (len < 4) ? len : 4);
            if (!fin) begin
                @(posedge clk);
                #1;
                if (mode == 0) out_ready = 1'b1;
                else out_ready = (c < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
        if (!fin) chk("timeout", 0, 1);
        if (!aborted) begin
            chk("done_after_last", done_c, (len == 0) ? 1 : last_hs + 1);
            chk("busy_at_done", busy, 0);
            chk("queues_empty", exp_q.size() + exp_addr_q.size(), 0);
            chk("word_count", popped, len);
            if (len == 0) begin
                chk("zero_no_issue", issued, 0);
                chk("zero_no_valid", first_v, -1);
            end else if (mode == 0) begin
                chk("first_en_lat", first_en, 1);
                chk("first_valid_lat", first_v, 3);
                chk("throughput", last_hs - first_v, len - 1);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = 16'h0000;
        length    = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_burst(16'h0010, 16'd4, 0, 0, 0);
        @(negedge clk);
        chk("done_pulse_a", done, 0);

        run_burst(16'hFFFE, 16'd4, 0, 0, 0);
        @(negedge clk);
        chk("done_pulse_b", done, 0);

        run_burst(16'h1234, 16'd0, 0, 0, 0);
        @(negedge clk);
        chk("done_pulse_c", done, 0);

        run_burst(16'h0200, 16'd16, 1, 0, 0);
        @(negedge clk);
        chk("done_pulse_d", done, 0);

        run_burst(16'h0300, 16'd10, 0, 0, 5);
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_valid", out_valid, 0);
        end
        run_burst(16'h0400, 16'd6, 1, 0, 0);
        @(negedge clk);
        chk("done_pulse_e", done, 0);

        run_burst(16'h0500, 16'd5, 0, 1, 0);
        @(negedge clk);
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_state", dbg_state, 0);
        run_burst(16'h0600, 16'd3, 0, 0, 0);
        @(negedge clk);
        chk("done_pulse_f", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
